// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: latches one raw message (hash, Merkle leaf pair or block header),
// then hands the padded 512-bit blocks to the compression core one at a time, paced by blk_done.
module sha256_msg_padder (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   type_in,
  input  logic [639:0] data_in,
  input  logic         blk_done,
  output logic [511:0] msg,
  output logic         msg_valid,
  output logic [1:0]   blk_type,
  output logic         first_blk,
  output logic         last_blk,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [1:0] T_HASH   = 2'd0;
  localparam logic [1:0] T_MERKLE = 2'd1;
  localparam logic [1:0] T_HEADER = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_idx;
  logic [127:0] r_tail;

  logic [511:0] w_block0;
  logic [511:0] w_block1;
  logic         w_next_idx;

  function automatic logic [511:0] f_block0(input logic [1:0] t, input logic [639:0] d);
    logic [511:0] res;
    res = 512'd0;
    case (t)
      T_HASH:   res = {d[255:0], 1'b1, 191'd0, 64'h100};
      T_MERKLE: res = d[511:0];
      T_HEADER: res = d[639:128];
      default:  res = 512'd0;
    endcase
    return res;
  endfunction

  // Only the header's trailing 128 bits survive into block 1; a leaf's block 1 is pure padding.
  function automatic logic [511:0] f_block1(input logic [1:0] t, input logic [127:0] tail);
    logic [511:0] res;
    res = 512'd0;
    case (t)
      T_MERKLE: res = {1'b1, 447'd0, 64'h200};
      T_HEADER: res = {tail, 1'b1, 319'd0, 64'h280};
      default:  res = 512'd0;
    endcase
    return res;
  endfunction

  assign w_block0   = f_block0(type_in, data_in);
  assign w_block1   = f_block1(blk_type, r_tail);
  assign w_next_idx = ~r_idx;

  // Block sequencer: accept, present each block for one SEND cycle, then wait for the core.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= 1'b0;
      r_tail    <= 128'd0;
      msg       <= 512'd0;
      msg_valid <= 1'b0;
      blk_type  <= 2'd0;
      first_blk <= 1'b0;
      last_blk  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      msg_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (type_in != 2'd3) begin
              r_tail    <= data_in[127:0];
              r_idx     <= 1'b0;
              blk_type  <= type_in;
              msg       <= w_block0;
              msg_valid <= 1'b1;
              first_blk <= 1'b1;
              last_blk  <= (type_in == T_HASH);
              busy      <= 1'b1;
              r_state   <= SEND;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SEND: r_state <= WAIT;
        WAIT: begin
          if (blk_done) begin
            if (last_blk) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_idx     <= w_next_idx;
              msg       <= w_block1;
              msg_valid <= 1'b1;
              first_blk <= (w_next_idx == 1'b0);
              last_blk  <= (blk_type == T_HASH) || (w_next_idx == 1'b1);
              r_state   <= SEND;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed and randomized bench for sha256_msg_padder; expected blocks come from a generic
// SHA-256 padding model (message || 1 || zeros || 64-bit length) built in the bench.
module tb_sha256_msg_padder;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   type_in = 2'd0;
  logic [639:0] data_in = 640'd0;
  logic         blk_done = 1'b0;
  logic [511:0] msg;
  logic         msg_valid;
  logic [1:0]   blk_type;
  logic         first_blk;
  logic         last_blk;
  logic         busy;
  logic         done;
  logic         err;

  int n_assert = 0;
  int n_fail = 0;
  int mv_cnt = 0;
  int done_cnt = 0;

  localparam logic [255:0] H = 256'hcdd1babeb9616ba90edc69a05c086b08b4ad1fee05e68c1093ba7b07328e1361;
  localparam logic [127:0] T = 128'hb4ad1fee05e68c1093ba7b07328e1361;

  sha256_msg_padder dut (
    .CLK(CLK), .reset(reset), .start(start), .type_in(type_in), .data_in(data_in),
    .blk_done(blk_done), .msg(msg), .msg_valid(msg_valid), .blk_type(blk_type),
    .first_blk(first_blk), .last_blk(last_blk), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  // Pulse counters sampled mid-cycle.
  always @(negedge CLK) begin
    if (msg_valid === 1'b1) mv_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk_v({tag, "_msg"}, msg, 512'd0);
    chk_b({tag, "_msg_valid"}, msg_valid, 1'b0);
    chk_b({tag, "_blk_type1"}, blk_type[1], 1'b0);
    chk_b({tag, "_blk_type0"}, blk_type[0], 1'b0);
    chk_b({tag, "_first"}, first_blk, 1'b0);
    chk_b({tag, "_last"}, last_blk, 1'b0);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_done"}, done, 1'b0);
    chk_b({tag, "_err"}, err, 1'b0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one message end to end; gap = cycles between msg_valid and blk_done.
  task automatic run_msg(input logic [1:0] t, input logic [639:0] d, input int gap, input bit abuse);
    int L, nb, tot, mv0, dn0;
    logic [1023:0] p;
    logic [511:0] blk;
    L = (t == 2'd0) ? 256 : (t == 2'd1) ? 512 : 640;
    nb = (L + 1 + 64 + 511) / 512;
    tot = nb * 512;
    p = '0;
    for (int i = 0; i < L; i++) p[tot-1-i] = d[L-1-i];
    p[tot-1-L] = 1'b1;
    p[63:0] = 64'(L);
    if (abuse) begin
      blk_done = 1'b1;
      tick();
      blk_done = 1'b0;
      chk_b("idle_blk_done_ignored", busy, 1'b0);
    end
    mv0 = mv_cnt;
    dn0 = done_cnt;
    start = 1'b1; type_in = t; data_in = d;
    tick();
    start = 1'b0;
    data_in = ~d;
    for (int k = 0; k < nb; k++) begin
      blk = p[tot-1-512*k -: 512];
      chk_b("msg_valid", msg_valid, 1'b1);
      chk_v("msg_block", msg, blk);
      chk_b("first_blk", first_blk, (k == 0));
      chk_b("last_blk", last_blk, (k == nb - 1));
      chk_b("busy", busy, 1'b1);
      chk_i("blk_type", int'(blk_type), int'(t));
      if (abuse) begin
        blk_done = 1'b1; start = 1'b1; type_in = 2'($urandom_range(0, 3));
      end
      tick();
      blk_done = 1'b0; start = 1'b0;
      chk_b("valid_drop", msg_valid, 1'b0);
      chk_v("msg_hold", msg, blk);
      for (int g = 1; g < gap; g++) begin
        if (abuse && g == 1) start = 1'b1;
        tick();
        start = 1'b0;
        chk_b("wait_valid", msg_valid, 1'b0);
        chk_b("wait_busy", busy, 1'b1);
      end
      blk_done = 1'b1;
      if (abuse) begin start = 1'b1; type_in = 2'd3; end
      tick();
      blk_done = 1'b0; start = 1'b0;
    end
    chk_b("done_pulse", done, 1'b1);
    chk_b("done_busy", busy, 1'b0);
    chk_b("done_err", err, 1'b0);
    tick();
    chk_b("done_one_cycle", done, 1'b0);
    chk_i("block_count", mv_cnt - mv0, nb);
    chk_i("done_count", done_cnt - dn0, 1);
  endtask

  initial begin
    logic [639:0] rd;
    logic [511:0] prev;
    int dn0;

    tick();
    chk_idle_zero("reset");
    tick();
    reset = 1'b0;
    tick();
    chk_idle_zero("post_reset");

    run_msg(2'd0, {384'd0, H}, 64, 1'b0);
    chk_v("hash_const", msg, {H, 1'b1, 191'd0, 64'h100});
    run_msg(2'd1, {128'd0, H, H}, 5, 1'b0);
    chk_v("merkle_b1_const", msg, {1'b1, 447'd0, 64'h200});
    run_msg(2'd2, {H, H, T}, 3, 1'b0);
    chk_v("header_b1_const", msg, {T, 1'b1, 319'd0, 64'h280});

    prev = msg;
    start = 1'b1; type_in = 2'd3; data_in = 640'd0;
    tick();
    start = 1'b0;
    chk_b("err_pulse", err, 1'b1);
    chk_b("err_busy", busy, 1'b0);
    chk_b("err_valid", msg_valid, 1'b0);
    chk_b("err_done", done, 1'b0);
    chk_v("err_msg_kept", msg, prev);
    tick();
    chk_b("err_one_cycle", err, 1'b0);

    run_msg(2'd2, {H, H, T}, 3, 1'b1);
    run_msg(2'd1, {128'd0, H, H}, 2, 1'b1);

    dn0 = done_cnt;
    start = 1'b1; type_in = 2'd2; data_in = {H, H, T};
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk_idle_zero("async_reset");
    tick();
    reset = 1'b0;
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
    tick();
    chk_i("reset_no_done", done_cnt - dn0, 0);
    chk_b("reset_idle_busy", busy, 1'b0);
    run_msg(2'd0, {384'd0, H}, 4, 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < 20; w++) rd[w*32 +: 32] = $urandom;
      run_msg(2'($urandom_range(0, 2)), rd, int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Upstream feeder for the SHA256 core inside processing_element. It accepts one raw message (a 256-bit hash, a 512-bit Merkle leaf pair, or a 640-bit block header), applies SHA-256 padding and length encoding, and delivers it to the core as one or two 512-bit blocks. It advances to the next block only after the core's blk_done. It replaces the hand-sequenced block feeding currently done in the bench.

## Interface

- No parameters.
- CLK  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- type_in  in  2  message type: 0 = HASH, 1 = MERKLE_LEAF, 2 = HEADER, 3 = reserved.
- data_in  in  640  raw message, right-aligned:
  - HASH uses [255:0].
  - MERKLE_LEAF uses [511:0].
  - HEADER uses [639:0].
  - Unused MSBs are ignored.
- blk_done  in  1  one-cycle pulse from the SHA256 core when the current block's compression has finished.
- msg  out  512  current padded block; held stable from its msg_valid cycle until the next block or reset.
- msg_valid  out  1  one-cycle pulse when msg holds a new block.
- blk_type  out  2  type of the message in flight; copied to the core.
- first_blk  out  1  high while msg is block 0 of a message; the core loads the IV.
- last_blk  out  1  high while msg is the final block.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final blk_done.
- err  out  1  one-cycle pulse when start is requested with type_in = 3.

## Operation

- Reset:
  - Asserting reset at any time, including mid-message, forces IDLE asynchronously.
  - All outputs go to 0: msg = 0, blk_type = 0, flags and pulses = 0.
  - Any in-flight message is discarded; no done pulse is produced.
- States: IDLE, SEND, WAIT.
- IDLE:
  - start = 1 with type_in in {0, 1, 2}: latch data_in and type_in, build block 0, go to SEND, busy = 1.
  - start = 1 with type_in = 3: err = 1 for one cycle, stay IDLE.
- SEND:
  - Lasts exactly one cycle, with msg_valid = 1.
  - Always goes to WAIT.
- WAIT:
  - msg_valid = 0; msg, first_blk and last_blk are held.
  - On blk_done with last_blk = 0: build the next block, go to SEND.
  - On blk_done with last_blk = 1: go to IDLE, busy = 0, done = 1 for one cycle.
- Block construction, MSB first:
  - HASH, 1 block: {d[255:0], 1'b1, 191'b0, 64'h100}.
  - MERKLE_LEAF, block 0: d[511:0].
  - MERKLE_LEAF, block 1: {1'b1, 447'b0, 64'h200}.
  - HEADER, block 0: d[639:128].
  - HEADER, block 1: {d[127:0], 1'b1, 319'b0, 64'h280}.
- The block index is a 1-bit counter; it cleared on acceptance and incremented on non-final blk_done.
- first_blk = (index == 0). last_blk = (HASH) or (index == 1).
- blk_type holds the latched type for the whole message and stays unchanged after done until the next accept.

## Timing

- Start latency: start sampled at edge t0 gives msg_valid = 1 and block 0 on msg during the cycle after t0.
- Inter-block latency: blk_done sampled at edge tn (non-final) gives block 1 on msg with msg_valid = 1 after tn.
- Done latency: final blk_done sampled at tn gives done = 1 and busy = 0 after tn. A new start can be sampled at tn+1.
- Per-message overhead: 1 cycle at start plus 1 cycle per block boundary, on top of core latency.
- Ignored inputs:
  - start while busy.
  - blk_done in IDLE or SEND; it is not queued.
- blk_done and start in the same cycle while in WAIT: blk_done is processed and start is ignored.
- A bit-flip on data_in after acceptance must not affect msg; data is fully latched at accept.

## Test plan

- HASH, data_in[255:0] = cdd1babeb9616ba90edc69a05c086b08b4ad1fee05e68c1093ba7b07328e1361, start:
  - msg_valid pulse one cycle later.
  - msg = {that value, 1, 191'b0, 64'h100}, first_blk = last_blk = 1.
  - blk_done 64 cycles later gives done one cycle after it and busy = 0.
- MERKLE_LEAF with the above 256-bit value repeated twice:
  - Block 0 = the 512-bit data, first_blk = 1.
  - After blk_done: block 1 = {1, 447'b0, 64'h200}, last_blk = 1, first_blk = 0.
  - Second blk_done gives done.
- HEADER with the 640-bit value cdd1…1361 ‖ cdd1…1361 ‖ b4ad1fee05e68c1093ba7b07328e1361:
  - Block 0 = upper 512 bits.
  - Block 1 = {b4ad…1361, 1, 319'b0, 64'h280}.
  - Exactly two msg_valid pulses and one done pulse.
- type_in = 3 with start:
  - err = 1 for one cycle; busy, msg_valid and done stay 0.
  - msg is unchanged.
- Protocol abuse:
  - start pulsed during WAIT, and blk_done pulsed during SEND and IDLE, are all ignored.
  - Block sequence and done count match the clean run.
- Reset during WAIT of a HEADER block 0:
  - All outputs are 0 immediately, no done pulse.
  - A subsequent HASH start completes normally.
